// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with per-entry saturating
//               direction counters and resolved/mispredicted branch counters.
//               Lookup is combinational off registered state; updates land
//               at the clock edge that ends the update cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_mispredict,
  input  logic        flush_all,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Counter encodings: saturation limits, weakly-taken and weakly-not-taken
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_MIN  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_WT   = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_CNT_WNT  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [31:0]      c_CNT32_MAX = 32'hFFFF_FFFF;

  // Table storage
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [CNT_W-1:0]   r_cnt    [ENTRIES];
  logic [31:0]        r_branch_cnt;
  logic [31:0]        r_mispred_cnt;

  // Lookup side
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [CNT_W-1:0] w_lk_cnt;

  // Update side
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic             w_up_write;
  logic             w_alloc;
  logic [CNT_W-1:0] w_up_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_dec;

  // Byte-offset bits of word-aligned PCs carry no information
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_lk_tag = lookup_pc[31:IDX_W+2];
  assign w_lk_cnt = r_cnt[w_lk_idx];

  assign pred_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign pred_taken  = pred_hit && w_lk_cnt[CNT_W-1];
  assign pred_target = pred_taken ? r_target[w_lk_idx] : (lookup_pc + 32'd4);

  assign w_up_idx   = update_pc[IDX_W+1:2];
  assign w_up_tag   = update_pc[31:IDX_W+2];
  assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  // flush_all drops any concurrent table update
  assign w_up_write = update_en && !flush_all;
  assign w_alloc    = w_up_write && !w_up_hit && update_taken;

  assign w_up_cnt  = r_cnt[w_up_idx];
  assign w_cnt_inc = (w_up_cnt == c_CNT_MAX) ? w_up_cnt : (w_up_cnt + c_CNT_ONE);
  assign w_cnt_dec = (w_up_cnt == c_CNT_MIN) ? w_up_cnt : (w_up_cnt - c_CNT_ONE);

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

  // Valid bits and direction counters: reset, flush, train on hit, allocate on taken miss
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i] <= c_CNT_WNT;
      end
    end else if (flush_all) begin
      r_valid <= '0;
    end else if (update_en) begin
      if (w_up_hit) begin
        r_cnt[w_up_idx] <= update_taken ? w_cnt_inc : w_cnt_dec;
      end else if (update_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_cnt[w_up_idx]   <= c_CNT_WT;
      end
    end
  end

  // Tags and targets need no reset: an entry is only ever read while its valid bit is set
  always_ff @(posedge CLK) begin
    if (w_up_write && update_taken) begin
      r_target[w_up_idx] <= update_target;
      if (w_alloc) begin
        r_tag[w_up_idx] <= w_up_tag;
      end
    end
  end

  // Resolved-branch and mispredict counters, saturating, counted even during flush
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (update_en) begin
      if (r_branch_cnt != c_CNT32_MAX) begin
        r_branch_cnt <= r_branch_cnt + 32'd1;
      end
      if (update_mispredict && (r_mispred_cnt != c_CNT32_MAX)) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed, table-driven bench for branch_predictor
//               (ENTRIES=16, CNT_W=2) plus a hand-written mid-update reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  logic        CLK;
  logic        RST;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic        flush_all;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .ENTRIES (16),
    .CNT_W   (2)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .lookup_pc         (lookup_pc),
    .pred_hit          (pred_hit),
    .pred_taken        (pred_taken),
    .pred_target       (pred_target),
    .update_en         (update_en),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .flush_all         (flush_all),
    .branch_cnt        (branch_cnt),
    .mispred_cnt       (mispred_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One cycle of stimulus plus the outputs expected during that cycle (pre-edge state)
  typedef struct {
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_tgt;
    logic        upd_mis;
    logic        flush;
    logic [31:0] lk_pc;
    logic        e_hit;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic [31:0] e_bcnt;
    logic [31:0] e_mcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ue, logic [31:0] upc, logic ut, logic [31:0] utg,
                              logic um, logic fl, logic [31:0] lpc, logic eh, logic et,
                              logic [31:0] etg, logic [31:0] eb, logic [31:0] em);
    vec_t v;
    v.upd_en = ue; v.upd_pc = upc; v.upd_taken = ut; v.upd_tgt = utg; v.upd_mis = um;
    v.flush = fl; v.lk_pc = lpc; v.e_hit = eh; v.e_taken = et; v.e_tgt = etg;
    v.e_bcnt = eb; v.e_mcnt = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic eh, input logic et,
                           input logic [31:0] etg, input logic [31:0] eb, input logic [31:0] em);
    check({tag, " hit"},    {31'd0, pred_hit},   {31'd0, eh});
    check({tag, " taken"},  {31'd0, pred_taken}, {31'd0, et});
    check({tag, " target"}, pred_target,          etg);
    check({tag, " bcnt"},   branch_cnt,           eb);
    check({tag, " mcnt"},   mispred_cnt,          em);
  endtask

  task automatic idle_inputs();
    update_en = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;
    update_mispredict = 1'b0; flush_all = 1'b0;
  endtask

  initial begin
    //          en pc            tk tgt           mis fl lookup        hit tk target        b   m
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h40,       0, 0, 32'h44,        0,  0));
    vecs.push_back(mk(1, 32'h40,       1, 32'h100,      0, 0, 32'h40,       0, 0, 32'h44,        0,  0));
    vecs.push_back(mk(1, 32'h40,       0, 32'h0,        1, 0, 32'h40,       1, 1, 32'h100,       1,  0));
    vecs.push_back(mk(1, 32'h40,       0, 32'h0,        0, 0, 32'h40,       1, 0, 32'h44,        2,  1));
    vecs.push_back(mk(1, 32'h40,       0, 32'h0,        0, 0, 32'h40,       1, 0, 32'h44,        3,  1));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h40,       1, 0, 32'h44,        4,  1));
    vecs.push_back(mk(1, 32'h40,       1, 32'h104,      0, 0, 32'h40,       1, 0, 32'h44,        4,  1));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h40,       1, 0, 32'h44,        5,  1));
    vecs.push_back(mk(1, 32'h40,       1, 32'h108,      0, 0, 32'h80,       0, 0, 32'h84,        5,  1));
    vecs.push_back(mk(1, 32'h40,       1, 32'h108,      0, 0, 32'h40,       1, 1, 32'h108,       6,  1));
    vecs.push_back(mk(1, 32'h40,       1, 32'h10C,      0, 0, 32'h40,       1, 1, 32'h108,       7,  1));
    vecs.push_back(mk(1, 32'h40,       0, 32'h0,        0, 0, 32'h40,       1, 1, 32'h10C,       8,  1));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h40,       1, 1, 32'h10C,       9,  1));
    vecs.push_back(mk(1, 32'h80,       0, 32'h0,        0, 0, 32'h80,       0, 0, 32'h84,        9,  1));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h40,       1, 1, 32'h10C,       10, 1));
    vecs.push_back(mk(1, 32'h80,       1, 32'h200,      1, 0, 32'h80,       0, 0, 32'h84,        10, 1));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h80,       1, 1, 32'h200,       11, 2));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h40,       0, 0, 32'h44,        11, 2));
    vecs.push_back(mk(1, 32'h1C,       1, 32'hFFFFFFFC, 0, 0, 32'h1C,       0, 0, 32'h20,        11, 2));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'hFFFFFFFC, 0, 0, 32'h0,         12, 2));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h1C,       1, 1, 32'hFFFFFFFC,  12, 2));
    vecs.push_back(mk(0, 32'h40,       1, 32'h300,      1, 0, 32'h40,       0, 0, 32'h44,        12, 2));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h40,       0, 0, 32'h44,        12, 2));
    vecs.push_back(mk(1, 32'h40,       1, 32'h400,      1, 1, 32'h80,       1, 1, 32'h200,       12, 2));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h80,       0, 0, 32'h84,        13, 3));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h1C,       0, 0, 32'h20,        13, 3));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h40,       0, 0, 32'h44,        13, 3));

    RST = 1'b1;
    lookup_pc = 32'h40;
    idle_inputs();
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      update_en         = vecs[i].upd_en;
      update_pc         = vecs[i].upd_pc;
      update_taken      = vecs[i].upd_taken;
      update_target     = vecs[i].upd_tgt;
      update_mispredict = vecs[i].upd_mis;
      flush_all         = vecs[i].flush;
      lookup_pc         = vecs[i].lk_pc;
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_taken,
                vecs[i].e_tgt, vecs[i].e_bcnt, vecs[i].e_mcnt);
    end

    // Re-populate entry 0 with a normal taken update
    @(negedge CLK);
    idle_inputs();
    update_en = 1'b1; update_pc = 32'h40; update_taken = 1'b1; update_target = 32'h500;
    lookup_pc = 32'h40;
    @(negedge CLK);
    idle_inputs();
    #1;
    check_all("refill", 1'b1, 1'b1, 32'h500, 32'd14, 32'd3);

    // Reset pulsed while an allocating, mispredicted update is presented
    @(negedge CLK);
    update_en = 1'b1; update_pc = 32'h1C; update_taken = 1'b1; update_target = 32'h600;
    update_mispredict = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 32'h44, 32'd0, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    idle_inputs();
    lookup_pc = 32'h1C;
    #1;
    check_all("rst_lost_upd", 1'b0, 1'b0, 32'h20, 32'd0, 32'd0);
    @(negedge CLK);
    lookup_pc = 32'h40;
    #1;
    check_all("rst_empty", 1'b0, 1'b0, 32'h44, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
